// File: rtl/counter_window_ctrl_pkg.sv
// Shared types for the counter window controller: FSM states and default width.
package counter_window_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/counter_window_ctrl_window_cmp.sv
// Window compare: hit when value lies in (lo, hi], unsigned; lo >= hi gives an empty window.
module window_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             hit
);

  assign hit = (value > lo) && (value <= hi);

endmodule

// File: rtl/counter_window_ctrl.sv
// Drives an external counter through a run of 0..limit and counts cycles spent inside a window.
module counter_window_ctrl
  import counter_window_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LO_DEF    = 5,
  parameter int HI_DEF    = 7,
  parameter int LIMIT_DEF = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             in_window,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hit_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] hit_q, hit_d;
  logic             win_hit;
  logic             in_run;
  logic             at_limit;
  logic             cfg_fire;

  window_cmp #(.WIDTH(WIDTH)) u_window_cmp (
    .value (count),
    .lo    (lo_q),
    .hi    (hi_q),
    .hit   (win_hit)
  );

  assign in_run   = (state_q == RUN);
  assign at_limit = (count == limit_q);
  assign cfg_fire = cfg_valid && cfg_ready;

  // Every decode is gated by reset so the outputs read 0 for as long as reset is held.
  assign cfg_ready = (state_q == IDLE) && !reset;
  assign cnt_clr   = (state_q == ARM) && !reset;
  assign cnt_en    = in_run && !at_limit && !abort && !reset;
  assign in_window = in_run && win_hit && !reset;
  assign busy      = ((state_q == ARM) || in_run) && !reset;
  assign done      = (state_q == DONE) && !reset;
  assign hit_count = hit_q;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    limit_d = limit_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          lo_d    = cfg_lo;
          hi_d    = cfg_hi;
          limit_d = cfg_limit;
        end
        if (start) begin
          state_d = ARM;
        end
      end
      ARM: begin
        hit_d   = '0;
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        if (in_window) begin
          hit_d = hit_q + WIDTH'(1);
        end
        // Abort wins over reaching the terminal count, so an aborted run never reaches DONE.
        if (abort) begin
          state_d = IDLE;
        end else if (at_limit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= WIDTH'(LO_DEF);
      hi_q    <= WIDTH'(HI_DEF);
      limit_q <= WIDTH'(LIMIT_DEF);
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      limit_q <= limit_d;
      hit_q   <= hit_d;
    end
  end

endmodule

// File: tb/tb_counter_window_ctrl.sv
// Bench for counter_window_ctrl: directed scenarios then random traffic, checked against a run-timeline model.
module tb_counter_window_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_lo = '0;
  logic [7:0] cfg_hi = '0;
  logic [7:0] cfg_limit = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] count = '0;
  logic       cnt_clr;
  logic       cnt_en;
  logic       in_window;
  logic       busy;
  logic       done;
  logic [7:0] hit_count;

  int tests = 0;
  int fails = 0;

  // Model: a run is described by the cycle its start was accepted plus its configuration.
  int         cyc = 0;
  bit         active = 1'b0;
  int         run_s = 0;
  int         m_lo = 5;
  int         m_hi = 7;
  int         m_lim = 10;
  int         exp_hit = 0;
  int         exp_cnt = 0;

  always #5 clk = ~clk;

  // External counter obeying the clear/enable contract.
  always @(posedge clk) begin
    if (cnt_clr) count <= 8'd0;
    else if (cnt_en) count <= count + 8'd1;
  end

  counter_window_ctrl #(
    .WIDTH(8), .LO_DEF(5), .HI_DEF(7), .LIMIT_DEF(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_limit (cfg_limit),
    .start     (start),
    .abort     (abort),
    .count     (count),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .in_window (in_window),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model over the edge.
  task automatic step(input bit r, input bit cv, input int lo, input int hi, input int lim,
                      input bit st, input bit ab);
    int  d;
    int  k;
    bit  arm_ph, run_ph, done_ph, exp_win, exp_en;
    @(negedge clk);
    reset     = r;
    cfg_valid = cv;
    cfg_lo    = 8'(lo);
    cfg_hi    = 8'(hi);
    cfg_limit = 8'(lim);
    start     = st;
    abort     = ab;
    #1;
    d       = active ? (cyc - run_s) : -1;
    k       = d - 2;
    arm_ph  = active && (d == 1);
    run_ph  = active && (d >= 2) && (d <= 2 + m_lim);
    done_ph = active && (d == 3 + m_lim);
    exp_win = run_ph && (k > m_lo) && (k <= m_hi);
    exp_en  = run_ph && (k != m_lim) && !ab;

    chk("cfg_ready", cfg_ready, !r && !active);
    chk("cnt_clr",   cnt_clr,   !r && arm_ph);
    chk("cnt_en",    cnt_en,    !r && exp_en);
    chk("in_window", in_window, !r && exp_win);
    chk("busy",      busy,      !r && (arm_ph || run_ph));
    chk("done",      done,      !r && done_ph);
    chk("hit_count", hit_count, 32'(exp_hit));
    chk("count",     count,     32'(exp_cnt));
    $display("[TB] cyc=%0d r=%0b cv=%0b st=%0b ab=%0b count=%0d win=%0b en=%0b busy=%0b done=%0b hits=%0d",
             cyc, r, cv, st, ab, count, in_window, cnt_en, busy, done, hit_count);

    if (r) begin
      active = 1'b0;
      m_lo = 5; m_hi = 7; m_lim = 10;
      exp_hit = 0;
    end else if (!active) begin
      if (cv) begin
        m_lo = lo; m_hi = hi; m_lim = lim;
      end
      if (st) begin
        active = 1'b1;
        run_s  = cyc;
      end
    end else if (arm_ph) begin
      exp_hit = 0;
      exp_cnt = 0;
      if (ab) active = 1'b0;
    end else if (run_ph) begin
      if (exp_win) exp_hit++;
      if (exp_en) exp_cnt = (exp_cnt + 1) % 256;
      if (ab) active = 1'b0;
    end else if (done_ph) begin
      active = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Reset state, then a run with the default 5/7/10 configuration.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(14);

    // Config and start together: window (0,3], limit 3.
    step(0, 1, 0, 3, 3, 1, 0);
    idle(7);

    // Inverted bounds give an empty window, done still pulses.
    step(0, 1, 7, 5, 10, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(14);

    // Abort in RUN at count 4.
    step(0, 1, 5, 7, 10, 1, 0);
    idle(5);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // limit 0, with a config offer during the single RUN cycle that must be ignored.
    step(0, 1, 0, 3, 0, 1, 0);
    idle(1);
    step(0, 1, 1, 2, 3, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(4);

    // Reset mid-run at count 6, then a run on the restored defaults.
    step(0, 1, 0, 9, 12, 1, 0);
    idle(7);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(14);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
